// File: rtl/spi_sclk_engine.sv
// SPI serial-clock and framing engine: SCLK for all CPOL/CPHA modes, chip-select
// setup/hold around a programmable bit count, and one-cycle sample/shift strobes.

module spi_sclk_engine_chk (
  input logic clk,
  input logic resetn,
  input logic i_cs_n,
  input logic i_busy,
  input logic i_lead_edge,
  input logic i_trail_edge,
  input logic i_sample_stb,
  input logic i_shift_stb,
  input logic i_done
);

  a_cs_matches_busy: assert property (@(posedge clk) disable iff (!resetn)
    (i_cs_n == !i_busy));

  a_edges_exclusive: assert property (@(posedge clk) disable iff (!resetn)
    !(i_lead_edge && i_trail_edge));

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (!resetn)
    !(i_sample_stb && i_shift_stb));

  a_strobe_on_edge: assert property (@(posedge clk) disable iff (!resetn)
    (i_sample_stb || i_shift_stb) |-> (i_lead_edge || i_trail_edge));

  a_done_when_idle: assert property (@(posedge clk) disable iff (!resetn)
    i_done |-> (i_cs_n && !i_busy));

endmodule

module spi_sclk_engine #(
  parameter int DIV_W       = 16,
  parameter int CNT_W       = 6,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic [DIV_W-1:0] i_clk_div,
  input  logic [CNT_W-1:0] i_num_bits,
  output logic             o_spi_clk,
  output logic             o_cs_n,
  output logic             o_busy,
  output logic             o_lead_edge,
  output logic             o_trail_edge,
  output logic             o_sample_stb,
  output logic             o_shift_stb,
  output logic             o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] DEF_HALF = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] HC_ZERO  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] HC_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   EC_ZERO  = {(CNT_W+1){1'b0}};
  localparam logic [CNT_W:0]   EC_ONE   = {{CNT_W{1'b0}}, 1'b1};

  state_t           r_state;
  logic [DIV_W-1:0] r_hcnt;
  logic [CNT_W:0]   r_ecnt;
  logic [DIV_W-1:0] r_half_m1;
  logic [CNT_W:0]   r_last_edge;
  logic             r_cpol;
  logic             r_cpha;
  logic             r_spi_clk;
  logic             r_cs_n;
  logic             r_busy;
  logic             r_lead;
  logic             r_trail;
  logic             r_sample;
  logic             r_shift;
  logic             r_done;

  logic [DIV_W-1:0] w_half;
  logic             w_start_ok;
  logic             w_hc_wrap;
  logic [CNT_W:0]   w_next_edge;
  logic             w_next_lead;
  logic             w_final;

  assign w_half      = (i_clk_div != HC_ZERO) ? i_clk_div : DEF_HALF;
  assign w_start_ok  = i_start & ~i_abort & (i_num_bits != {CNT_W{1'b0}});
  assign w_hc_wrap   = (r_hcnt == r_half_m1);
  assign w_next_edge = r_ecnt + EC_ONE;
  // Odd edge numbers leave the idle level, even ones return to it.
  assign w_next_lead = w_next_edge[0];
  assign w_final     = (w_next_edge == r_last_edge);

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_hcnt      <= HC_ZERO;
      r_ecnt      <= EC_ZERO;
      r_half_m1   <= HC_ZERO;
      r_last_edge <= EC_ZERO;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_spi_clk   <= i_cpol;
      r_cs_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_lead      <= 1'b0;
      r_trail     <= 1'b0;
      r_sample    <= 1'b0;
      r_shift     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_lead   <= 1'b0;
      r_trail  <= 1'b0;
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
      r_done   <= 1'b0;
      if (i_abort && (r_state != ST_IDLE)) begin
        r_state   <= ST_IDLE;
        r_hcnt    <= HC_ZERO;
        r_ecnt    <= EC_ZERO;
        r_spi_clk <= r_cpol;
        r_cs_n    <= 1'b1;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_spi_clk <= i_cpol;
            r_hcnt    <= HC_ZERO;
            r_ecnt    <= EC_ZERO;
            if (w_start_ok) begin
              r_cpol      <= i_cpol;
              r_cpha      <= i_cpha;
              r_half_m1   <= w_half - HC_ONE;
              r_last_edge <= {i_num_bits, 1'b0};
              r_cs_n      <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= ST_SETUP;
            end else begin
              r_cs_n <= 1'b1;
              r_busy <= 1'b0;
            end
          end
          // SETUP ends with edge 1, so it shares the edge logic with RUN.
          ST_SETUP, ST_RUN: begin
            if (w_hc_wrap) begin
              r_hcnt    <= HC_ZERO;
              r_ecnt    <= w_next_edge;
              r_spi_clk <= ~r_spi_clk;
              r_lead    <= w_next_lead;
              r_trail   <= ~w_next_lead;
              r_sample  <= r_cpha ? ~w_next_lead : w_next_lead;
              r_shift   <= r_cpha ? w_next_lead : (~w_next_lead & ~w_final);
              r_state   <= w_final ? ST_HOLD : ST_RUN;
            end else begin
              r_hcnt <= r_hcnt + HC_ONE;
            end
          end
          ST_HOLD: begin
            if (w_hc_wrap) begin
              r_hcnt  <= HC_ZERO;
              r_ecnt  <= EC_ZERO;
              r_cs_n  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_hcnt <= r_hcnt + HC_ONE;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_hcnt    <= HC_ZERO;
            r_ecnt    <= EC_ZERO;
            r_spi_clk <= r_cpol;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_spi_clk    = r_spi_clk;
  assign o_cs_n       = r_cs_n;
  assign o_busy       = r_busy;
  assign o_lead_edge  = r_lead;
  assign o_trail_edge = r_trail;
  assign o_sample_stb = r_sample;
  assign o_shift_stb  = r_shift;
  assign o_done       = r_done;

  spi_sclk_engine_chk u_chk (
    .clk          (clk),
    .resetn       (resetn),
    .i_cs_n       (r_cs_n),
    .i_busy       (r_busy),
    .i_lead_edge  (r_lead),
    .i_trail_edge (r_trail),
    .i_sample_stb (r_sample),
    .i_shift_stb  (r_shift),
    .i_done       (r_done)
  );

endmodule

// File: doc/spi_sclk_engine.md
# spi_sclk_engine

Parametrised SPI serial-clock and framing engine, the successor to the free-running SPI clock divider. It generates SCLK for all four CPOL/CPHA modes and frames a transfer of a programmable bit count with chip-select setup and hold. It also emits one-cycle sample/shift strobes, so the SPI shift register needs no edge detection. It sits between the AXI-Lite register block, which supplies the configuration, and the SPI shifter/pad logic.

## Interface
Parameters:
- DIV_W, 16: width of clk_div.
- CNT_W, 6: width of num_bits; max frame is 2^CNT_W-1 bits.
- DEFAULT_DIV, 4: half-period used when clk_div==0.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to begin a frame; ignored while busy.
- abort  in  1  synchronous cancel of the current frame.
- cpol  in  1  idle clock level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- clk_div  in  DIV_W  SCLK half-period in clk cycles; 0 selects DEFAULT_DIV.
- num_bits  in  CNT_W  bits per frame; 0 means start is ignored.
- spi_clk  out  1  SCLK, registered.
- cs_n  out  1  chip select, active-low, registered.
- busy  out  1  frame in progress.
- lead_edge  out  1  pulse when spi_clk shows a leading (idle→active) edge.
- trail_edge  out  1  pulse when spi_clk shows a trailing edge.
- sample_stb  out  1  pulse: shifter samples MISO.
- shift_stb  out  1  pulse: shifter drives next MOSI bit.
- done  out  1  one-cycle pulse when a frame completes normally.

## Operation
- Half-period H = (clk_div!=0) ? clk_div : DEFAULT_DIV.
- start latches cpol, cpha, H and N=num_bits. Changes to these inputs during a frame have no effect.
- States: IDLE → SETUP → RUN → HOLD → IDLE.
- IDLE: spi_clk <= cpol (live input) every cycle, cs_n=1, busy=0. start with N!=0 → SETUP.
- SETUP: cs_n=0, busy=1, spi_clk at idle level for H cycles → RUN.
- RUN: spi_clk toggles every H cycles for exactly 2N edges. Edge k (1..2N) is leading if k is odd and trailing if k is even. After edge 2N → HOLD.
- HOLD: spi_clk at idle level for H cycles. Then cs_n=1, busy=0, done=1 for one cycle → IDLE.
- cpha=0: sample_stb on every leading edge. shift_stb on every trailing edge except edge 2N (suppressed). The shifter preloads bit 0 at start.
- cpha=1: shift_stb on every leading edge, sample_stb on every trailing edge.
- Totals per frame: exactly N sample_stb pulses. shift_stb is N-1 pulses when cpha=0 and N when cpha=1.
- abort in any non-IDLE state → next cycle IDLE: spi_clk=latched cpol, cs_n=1, busy=0, no done, no strobes. abort in IDLE has no effect.
- start and abort in the same cycle while IDLE: abort wins and no frame starts.
- Width rules:
  - Half-period counter is DIV_W bits and counts 0..H-1.
  - Edge counter is CNT_W+1 bits and counts 1..2N.
  - No wrap is possible at maximum values (clk_div=2^DIV_W-1, num_bits=2^CNT_W-1).

## Timing
- Reset values: spi_clk=cpol (input level at reset), cs_n=1, busy=0; all strobes and done 0. State IDLE, counters 0.
- Cycle numbering: start sampled high at cycle 0.
- Cycle 1: cs_n=0, busy=1.
- Edge k first appears on spi_clk at cycle k·H+1. lead_edge/trail_edge and sample_stb/shift_stb are high in that same cycle only.
- Last edge appears at cycle 2N·H+1.
- Cycle (2N+1)·H+1: done=1, cs_n=1, busy=0.
- A new start is accepted in the cycle done is high, since the block is already IDLE. Minimum cs_n high time is therefore 1 cycle.
- H=1 is legal: spi_clk toggles every cycle and strobes occur on consecutive cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then run with clk_div=0 (H=4), N=8, cpol=0, cpha=0:
  - Required: first rise at cycle 5, last edge at cycle 65, done at cycle 69.
  - Required: 8 sample_stb on rising edges and 7 shift_stb on falling edges.
- All four modes with clk_div=3, N=5:
  - Required: idle level equals cpol.
  - Required: strobe-to-edge mapping follows cpha; sample_stb count is 5 and shift_stb count is 4 (cpha=0) or 5 (cpha=1).
- clk_div=1, N=2:
  - Required: edges at cycles 2, 3, 4, 5; done at cycle 6.
  - Then issue start in the done cycle; required: second frame cs_n=0 at cycle 7.
- Abort at cycle 20 of a H=4, N=8 frame:
  - Required at cycle 21: cs_n=1, busy=0, spi_clk=cpol.
  - Required: no done and no further strobes.
- Negative cases:
  - start with num_bits=0 → required: no activity.
  - start while busy → required: ignored.
  - clk_div changed mid-frame → required: period unchanged.
- Assert resetn low mid-RUN → required: outputs return to reset values immediately (asynchronous).
- Deassert resetn → required: stays IDLE until the next start.
